lcd_text_ctrl: RTL

Parametrised HD44780-class character-LCD text controller. Initialises the panel after a start request, then drains bytes from a show-ahead FIFO and renders them as a text terminal of ROWS×COLS characters, with cursor tracking, line wrap, newline, backspace and form-feed. It sits between the keyboard/UART byte FIFO and the LCD pins, replacing the fixed 2×16 print-only controller. The RW line is tied low: the block never reads the busy flag and relies on fixed cycle-count delays.

---
 rtl/lcd_text_ctrl.sv | 316 +++++++++++++++++++++++++++++++
 1 files changed

// File: rtl/lcd_text_ctrl.sv
// HD44780-class character-LCD text terminal: panel init, then FIFO bytes
// rendered as a ROWS x COLS terminal with wrap, newline, backspace and clear.
module lcd_text_ctrl #(
    parameter int unsigned ROWS   = 2,
    parameter int unsigned COLS   = 16,
    parameter int unsigned T_PWR  = 750000,
    parameter int unsigned T_AS   = 2,
    parameter int unsigned T_EN   = 12,
    parameter int unsigned T_WAIT = 2500,
    parameter int unsigned T_CLR  = 100000,
    localparam int unsigned ROW_W = (ROWS > 1) ? $clog2(ROWS) : 1,
    localparam int unsigned COL_W = $clog2(COLS + 1)
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             start,
    input  logic [7:0]       fifo_data,
    input  logic             fifo_empty,
    output logic             fifo_rd,
    output logic [7:0]       lcd_data,
    output logic             lcd_rs,
    output logic             lcd_rw,
    output logic             lcd_en,
    output logic             ready,
    output logic             busy,
    output logic [ROW_W-1:0] cursor_row,
    output logic [COL_W-1:0] cursor_col
);

    localparam int unsigned T_MAX_A  = (T_PWR > T_CLR) ? T_PWR : T_CLR;
    localparam int unsigned T_MAX_B  = (T_WAIT > T_EN) ? T_WAIT : T_EN;
    localparam int unsigned T_MAX_C  = (T_MAX_B > T_AS) ? T_MAX_B : T_AS;
    localparam int unsigned T_MAX    = (T_MAX_A > T_MAX_C) ? T_MAX_A : T_MAX_C;
    localparam int unsigned CNT_W    = $clog2(T_MAX + 1);
    localparam int unsigned LAST_ROW = ROWS - 1;

    localparam logic [7:0] CMD_FUNC  = (ROWS == 1) ? 8'h30 : 8'h38;
    localparam logic [7:0] CMD_DISP  = 8'h0C;
    localparam logic [7:0] CMD_ENTRY = 8'h06;
    localparam logic [7:0] CMD_CLEAR = 8'h01;

    typedef enum logic [2:0] {
        S_IDLE,
        S_PWR,
        S_INIT,
        S_READY,
        S_EXEC
    } state_t;

    typedef enum logic [1:0] {
        PH_SETUP,
        PH_PULSE,
        PH_HOLD
    } phase_t;

    typedef struct packed {
        logic       rs;
        logic [7:0] data;
    } txn_t;

    // Transaction list and resulting cursor for one received byte
    typedef struct packed {
        logic [1:0]       n;
        txn_t [2:0]       t;
        logic [ROW_W-1:0] row;
        logic [COL_W-1:0] col;
    } plan_t;

    state_t           state, state_d;
    phase_t           phase, phase_d;
    logic [CNT_W-1:0] cnt, cnt_d;
    logic [1:0]       idx, idx_d;
    logic [2:0]       n, n_d;
    txn_t [3:0]       txn, txn_d;
    logic [ROW_W-1:0] pend_row, pend_row_d;
    logic [COL_W-1:0] pend_col, pend_col_d;

    logic             fifo_rd_d;
    logic [7:0]       lcd_data_d;
    logic             lcd_rs_d;
    logic             lcd_en_d;
    logic             ready_d;
    logic             busy_d;
    logic [ROW_W-1:0] cursor_row_d;
    logic [COL_W-1:0] cursor_col_d;

    plan_t            plan;
    txn_t             cur;
    txn_t             nxt;
    logic             is_clear;
    logic [2:0]       idx_next;

    assign lcd_rw = 1'b0;

    // DDRAM set-address command for a (row, col) position
    function automatic logic [7:0] set_addr(input int unsigned r, input int unsigned c);
        int unsigned a;
        a = (r % 2) * 32'h40 + (r / 2) * COLS + c;
        return 8'h80 | 8'(a);
    endfunction

    // Translate one byte at the current cursor into bus transactions
    function automatic plan_t decode(input logic [7:0] b,
                                     input logic [ROW_W-1:0] row,
                                     input logic [COL_W-1:0] col);
        plan_t       p;
        int unsigned r;
        int unsigned c;
        p = '0;
        r = 32'(row);
        c = 32'(col);
        if (b >= 8'h20 && b <= 8'h7E) begin
            p.n    = 2'd1;
            p.t[0] = {1'b1, b};
            c      = c + 1;
            if (c == COLS) begin
                p.n = 2'd2;
                if (r < LAST_ROW) begin
                    r      = r + 1;
                    c      = 0;
                    p.t[1] = {1'b0, set_addr(r, c)};
                end else begin
                    r      = 0;
                    c      = 0;
                    p.t[1] = {1'b0, CMD_CLEAR};
                end
            end
        end else if (b == 8'h0A) begin
            p.n = 2'd1;
            if (r < LAST_ROW) begin
                r      = r + 1;
                c      = 0;
                p.t[0] = {1'b0, set_addr(r, c)};
            end else begin
                r      = 0;
                c      = 0;
                p.t[0] = {1'b0, CMD_CLEAR};
            end
        end else if (b == 8'h08) begin
            if (c > 0 || r > 0) begin
                if (c > 0) begin
                    c = c - 1;
                end else begin
                    r = r - 1;
                    c = COLS - 1;
                end
                p.n    = 2'd3;
                p.t[0] = {1'b0, set_addr(r, c)};
                p.t[1] = {1'b1, 8'h20};
                p.t[2] = {1'b0, set_addr(r, c)};
            end
        end else if (b == 8'h0C) begin
            p.n    = 2'd1;
            p.t[0] = {1'b0, CMD_CLEAR};
            r      = 0;
            c      = 0;
        end
        p.row = ROW_W'(r);
        p.col = COL_W'(c);
        return p;
    endfunction

    // State and registered outputs
    always_ff @(posedge clock) begin
        if (reset) begin
            state      <= S_IDLE;
            phase      <= PH_SETUP;
            cnt        <= '0;
            idx        <= '0;
            n          <= '0;
            txn        <= '0;
            pend_row   <= '0;
            pend_col   <= '0;
            fifo_rd    <= 1'b0;
            lcd_data   <= '0;
            lcd_rs     <= 1'b0;
            lcd_en     <= 1'b0;
            ready      <= 1'b0;
            busy       <= 1'b0;
            cursor_row <= '0;
            cursor_col <= '0;
        end else begin
            state      <= state_d;
            phase      <= phase_d;
            cnt        <= cnt_d;
            idx        <= idx_d;
            n          <= n_d;
            txn        <= txn_d;
            pend_row   <= pend_row_d;
            pend_col   <= pend_col_d;
            fifo_rd    <= fifo_rd_d;
            lcd_data   <= lcd_data_d;
            lcd_rs     <= lcd_rs_d;
            lcd_en     <= lcd_en_d;
            ready      <= ready_d;
            busy       <= busy_d;
            cursor_row <= cursor_row_d;
            cursor_col <= cursor_col_d;
        end
    end

    // Next-state: sequencing, bus engine phases and cursor commit
    always_comb begin
        state_d      = state;
        phase_d      = phase;
        cnt_d        = cnt;
        idx_d        = idx;
        n_d          = n;
        txn_d        = txn;
        pend_row_d   = pend_row;
        pend_col_d   = pend_col;
        fifo_rd_d    = 1'b0;
        lcd_data_d   = lcd_data;
        lcd_rs_d     = lcd_rs;
        ready_d      = ready;
        cursor_row_d = cursor_row;
        cursor_col_d = cursor_col;

        plan     = decode(fifo_data, cursor_row, cursor_col);
        cur      = txn[idx];
        is_clear = !cur.rs && (cur.data == CMD_CLEAR);
        idx_next = 3'(idx) + 3'd1;
        nxt      = txn[2'(idx_next)];

        case (state)
            S_IDLE: begin
                if (start) begin
                    state_d = S_PWR;
                    cnt_d   = CNT_W'(T_PWR - 1);
                end
            end

            S_PWR: begin
                if (cnt != '0) begin
                    cnt_d = cnt - CNT_W'(1);
                end else begin
                    state_d    = S_INIT;
                    txn_d[0]   = {1'b0, CMD_FUNC};
                    txn_d[1]   = {1'b0, CMD_DISP};
                    txn_d[2]   = {1'b0, CMD_ENTRY};
                    txn_d[3]   = {1'b0, CMD_CLEAR};
                    n_d        = 3'd4;
                    idx_d      = '0;
                    phase_d    = PH_SETUP;
                    cnt_d      = CNT_W'(T_AS - 1);
                    lcd_rs_d   = 1'b0;
                    lcd_data_d = CMD_FUNC;
                end
            end

            S_READY: begin
                if (!fifo_empty) begin
                    fifo_rd_d  = 1'b1;
                    state_d    = S_EXEC;
                    txn_d[0]   = plan.t[0];
                    txn_d[1]   = plan.t[1];
                    txn_d[2]   = plan.t[2];
                    n_d        = 3'(plan.n);
                    idx_d      = '0;
                    pend_row_d = plan.row;
                    pend_col_d = plan.col;
                    if (plan.n != 2'd0) begin
                        phase_d    = PH_SETUP;
                        cnt_d      = CNT_W'(T_AS - 1);
                        lcd_rs_d   = plan.t[0].rs;
                        lcd_data_d = plan.t[0].data;
                    end else begin
                        phase_d = PH_HOLD;
                    end
                end
            end

            S_INIT, S_EXEC: begin
                if (n == 3'd0) begin
                    state_d = S_READY;
                end else if (cnt != '0) begin
                    cnt_d = cnt - CNT_W'(1);
                end else begin
                    case (phase)
                        PH_SETUP: begin
                            phase_d = PH_PULSE;
                            cnt_d   = CNT_W'(T_EN - 1);
                        end
                        PH_PULSE: begin
                            phase_d = PH_HOLD;
                            cnt_d   = is_clear ? CNT_W'(T_CLR - 1) : CNT_W'(T_WAIT - 1);
                        end
                        default: begin
                            if (idx_next < n) begin
                                idx_d      = 2'(idx_next);
                                phase_d    = PH_SETUP;
                                cnt_d      = CNT_W'(T_AS - 1);
                                lcd_rs_d   = nxt.rs;
                                lcd_data_d = nxt.data;
                            end else begin
                                state_d = S_READY;
                                if (state == S_INIT) begin
                                    ready_d = 1'b1;
                                end else begin
                                    cursor_row_d = pend_row;
                                    cursor_col_d = pend_col;
                                end
                            end
                        end
                    endcase
                end
            end

            default: state_d = S_IDLE;
        endcase

        lcd_en_d = ((state_d == S_INIT) || (state_d == S_EXEC)) && (phase_d == PH_PULSE);
        busy_d   = (state_d == S_PWR) || (state_d == S_INIT) || (state_d == S_EXEC);
    end

endmodule
